// File: rtl/rf_writeback_ctrl.sv
// rf_writeback_ctrl: merges ALU results (no backpressure) and load results
// (valid/ready) into a single registered register-file write stream.
// The ALU has priority; loads that lose the port wait in a small in-order
// queue. x0 writes are dropped, and an ALU write kills any queued load that
// targets the same register (write-after-write).
// Optional feature: define RF_WB_BYPASS_EN to add combinational forwarding
// ports (byp_rs1/byp_rs2 -> byp_hit1/2, byp_data1/2) for decode.
module rf_writeback_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int QDEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alu_valid,
  input  logic [ADDR_W-1:0]           alu_rd,
  input  logic [DATA_W-1:0]           alu_data,
  input  logic                        ld_valid,
  output logic                        ld_ready,
  input  logic [ADDR_W-1:0]           ld_rd,
  input  logic [DATA_W-1:0]           ld_data,
  output logic                        rf_wen,
  output logic [ADDR_W-1:0]           rf_rd,
  output logic [DATA_W-1:0]           rf_wdata,
  output logic [$clog2(QDEPTH):0]     q_count
`ifdef RF_WB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0]           byp_rs1,
  input  logic [ADDR_W-1:0]           byp_rs2,
  output logic                        byp_hit1,
  output logic                        byp_hit2,
  output logic [DATA_W-1:0]           byp_data1,
  output logic [DATA_W-1:0]           byp_data2
`endif
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  // Queue storage: one valid bit per entry so WAW kills can retire an entry
  // without writing it.
  logic [QDEPTH-1:0][ADDR_W-1:0] qrd_q, qrd_d;
  logic [QDEPTH-1:0][DATA_W-1:0] qdata_q, qdata_d;
  logic [QDEPTH-1:0]             qvld_q, qvld_d;
  logic [PW-1:0]                 head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]                 count_q, count_d;

  logic                          rf_wen_q, rf_wen_d;
  logic [ADDR_W-1:0]             rf_rd_q, rf_rd_d;
  logic [DATA_W-1:0]             rf_wdata_q, rf_wdata_d;

  logic alu_w, ld_acc, q_empty, pop, byp, push;

  // Handshake and write-port arbitration decisions for this cycle.
  always_comb begin
    ld_ready = !rst && (count_q < CW'(QDEPTH));
    alu_w    = alu_valid && (alu_rd != '0);
    ld_acc   = ld_valid && ld_ready;
    q_empty  = (count_q == '0);
    pop      = !alu_w && !q_empty;
    byp      = !alu_w && q_empty && ld_acc && (ld_rd != '0);
    push     = ld_acc && (ld_rd != '0) && !byp;
  end

  // Next-state for the write port, queue contents and pointers.
  always_comb begin
    rf_wen_d   = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    qrd_d      = qrd_q;
    qdata_d    = qdata_q;
    qvld_d     = qvld_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;

    if (alu_w) begin
      rf_wen_d   = 1'b1;
      rf_rd_d    = alu_rd;
      rf_wdata_d = alu_data;
      // Older queued loads to the same rd are now stale.
      for (int i = 0; i < QDEPTH; i++)
        if (qrd_q[i] == alu_rd) qvld_d[i] = 1'b0;
    end else if (pop) begin
      // A killed head still consumes its slot and the cycle, with no write.
      rf_wen_d = qvld_q[head_q];
      if (qvld_q[head_q]) begin
        rf_rd_d    = qrd_q[head_q];
        rf_wdata_d = qdata_q[head_q];
      end
      qvld_d[head_q] = 1'b0;
      head_d         = head_q + PW'(1);
    end else if (byp) begin
      rf_wen_d   = 1'b1;
      rf_rd_d    = ld_rd;
      rf_wdata_d = ld_data;
    end

    // Push after the kill so a load accepted alongside the ALU write survives.
    if (push) begin
      qrd_d[tail_q]   = ld_rd;
      qdata_d[tail_q] = ld_data;
      qvld_d[tail_q]  = 1'b1;
      tail_d          = tail_q + PW'(1);
    end

    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  // State registers; synchronous reset clears the port and empties the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wen_q   <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
      qrd_q      <= '0;
      qdata_q    <= '0;
      qvld_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      rf_wen_q   <= rf_wen_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
      qrd_q      <= qrd_d;
      qdata_q    <= qdata_d;
      qvld_q     <= qvld_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_rd    = rf_rd_q;
  assign rf_wdata = rf_wdata_q;
  assign q_count  = count_q;

`ifdef RF_WB_BYPASS_EN
  logic [PW-1:0] bidx;

  // Forwarding: registered write first, then queued entries oldest to
  // youngest so the youngest valid match wins.
  always_comb begin
    byp_hit1  = 1'b0;
    byp_hit2  = 1'b0;
    byp_data1 = '0;
    byp_data2 = '0;
    bidx      = head_q;
    if (rf_wen_q && rf_rd_q == byp_rs1) begin
      byp_hit1  = 1'b1;
      byp_data1 = rf_wdata_q;
    end
    if (rf_wen_q && rf_rd_q == byp_rs2) begin
      byp_hit2  = 1'b1;
      byp_data2 = rf_wdata_q;
    end
    for (int i = 0; i < QDEPTH; i++) begin
      bidx = head_q + PW'(i);
      if (CW'(i) < count_q && qvld_q[bidx]) begin
        if (qrd_q[bidx] == byp_rs1) begin
          byp_hit1  = 1'b1;
          byp_data1 = qdata_q[bidx];
        end
        if (qrd_q[bidx] == byp_rs2) begin
          byp_hit2  = 1'b1;
          byp_data2 = qdata_q[bidx];
        end
      end
    end
    if (byp_rs1 == '0) begin
      byp_hit1  = 1'b0;
      byp_data1 = '0;
    end
    if (byp_rs2 == '0) begin
      byp_hit2  = 1'b0;
      byp_data2 = '0;
    end
  end
`endif

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Bench for rf_writeback_ctrl: a queue-based reference model of the write
// port is advanced every cycle alongside the DUT and compared after each edge;
// literal checks pin the model at key points of each directed scenario.
module tb_rf_writeback_ctrl;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int QD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          alu_valid = 1'b0;
  logic [AW-1:0] alu_rd = '0;
  logic [DW-1:0] alu_data = '0;
  logic          ld_valid = 1'b0;
  logic          ld_ready;
  logic [AW-1:0] ld_rd = '0;
  logic [DW-1:0] ld_data = '0;
  logic          rf_wen;
  logic [AW-1:0] rf_rd;
  logic [DW-1:0] rf_wdata;
  logic [2:0]    q_count;
`ifdef RF_WB_BYPASS_EN
  logic [AW-1:0] byp_rs1 = '0;
  logic [AW-1:0] byp_rs2 = '0;
  logic          byp_hit1, byp_hit2;
  logic [DW-1:0] byp_data1, byp_data2;
`endif

  rf_writeback_ctrl #(.DATA_W(DW), .ADDR_W(AW), .QDEPTH(QD)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .q_count(q_count)
`ifdef RF_WB_BYPASS_EN
    , .byp_rs1(byp_rs1), .byp_rs2(byp_rs2), .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
    .byp_data1(byp_data1), .byp_data2(byp_data2)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
    bit            live;
  } ent_t;

  ent_t          mq[$];
  logic          e_wen = 1'b0;
  logic [AW-1:0] e_rd = '0;
  logic [DW-1:0] e_data = '0;
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

`ifdef RF_WB_BYPASS_EN
  task automatic model_byp(input logic [AW-1:0] rs, output logic hit, output logic [DW-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (rs != 0) begin
      if (e_wen && e_rd == rs) begin hit = 1'b1; d = e_data; end
      foreach (mq[i])
        if (mq[i].live && mq[i].rd == rs) begin hit = 1'b1; d = mq[i].data; end
    end
  endtask

  task automatic chk_byp();
    logic h; logic [DW-1:0] d;
    model_byp(byp_rs1, h, d);
    chk("byp_hit1", DW'(byp_hit1), DW'(h));
    chk("byp_data1", byp_data1, d);
    model_byp(byp_rs2, h, d);
    chk("byp_hit2", DW'(byp_hit2), DW'(h));
    chk("byp_data2", byp_data2, d);
  endtask
`endif

  // One clock: drive inputs, advance the model by the write-port rules,
  // then compare all outputs one time unit after the edge.
  task automatic step(input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                      input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ldd,
                      input logic r, output bit acc);
    ent_t h;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    ld_valid = lv; ld_rd = lrd; ld_data = ldd; rst = r;
    acc = lv && !r && (mq.size() < QD);
    if (r) begin
      mq.delete();
      e_wen = 1'b0; e_rd = '0; e_data = '0;
    end else if (av && ard != 0) begin
      e_wen = 1'b1; e_rd = ard; e_data = ad;
      foreach (mq[i]) if (mq[i].rd == ard) mq[i].live = 1'b0;
      if (acc && lrd != 0) mq.push_back('{lrd, ldd, 1'b1});
    end else if (mq.size() > 0) begin
      h = mq.pop_front();
      e_wen = h.live;
      if (h.live) begin e_rd = h.rd; e_data = h.data; end
      if (acc && lrd != 0) mq.push_back('{lrd, ldd, 1'b1});
    end else if (acc && lrd != 0) begin
      e_wen = 1'b1; e_rd = lrd; e_data = ldd;
    end else begin
      e_wen = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("rf_wen", DW'(rf_wen), DW'(e_wen));
    chk("rf_rd", DW'(rf_rd), DW'(e_rd));
    chk("rf_wdata", rf_wdata, e_data);
    chk("q_count", DW'(q_count), DW'(mq.size()));
    chk("ld_ready", DW'(ld_ready), DW'(!r && mq.size() < QD));
`ifdef RF_WB_BYPASS_EN
    chk_byp();
`endif
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, a);
  endtask

  initial begin
    bit a;
    int k;

    // Reset state
    step(0, 0, 0, 0, 0, 0, 1, a);
    step(0, 0, 0, 0, 0, 0, 1, a);
    chk("rst_wen", DW'(rf_wen), 0);
    chk("rst_ready", DW'(ld_ready), 0);
    idle(1);
    chk("rel_ready", DW'(ld_ready), 1);

    // T2 collision: ALU wins, load queued then written next cycle
    step(1, 5, 32'h11, 1, 6, 32'hAA, 0, a);
    chk("t2_rd1", DW'(rf_rd), 5);
    chk("t2_d1", rf_wdata, 32'h11);
    chk("t2_q1", DW'(q_count), 1);
    idle(1);
    chk("t2_rd2", DW'(rf_rd), 6);
    chk("t2_d2", rf_wdata, 32'hAA);
    chk("t2_q2", DW'(q_count), 0);

    // T3 full: ALU holds the port, four loads fill the queue, fifth stalls
    k = 0;
    for (int c = 0; c < 6; c++) begin
      step(1, 1, 32'h50 + c, 1, AW'(10 + k), 32'h100 + k, 0, a);
      if (a) k++;
    end
    chk("t3_k", k, 4);
    chk("t3_qfull", DW'(q_count), 4);
    chk("t3_nready", DW'(ld_ready), 0);
    step(0, 0, 0, 1, AW'(10 + k), 32'h100 + k, 0, a);
    chk("t3_pop_rd", DW'(rf_rd), 10);
    chk("t3_pop_d", rf_wdata, 32'h100);
    chk("t3_ready", DW'(ld_ready), 1);
    step(0, 0, 0, 1, AW'(10 + k), 32'h100 + k, 0, a);
    chk("t3_acc5", DW'(a), 1);
    chk("t3_rd11", DW'(rf_rd), 11);
    idle(5);
    chk("t3_last", DW'(rf_rd), 14);
    chk("t3_empty", DW'(q_count), 0);

    // T4 x0: neither source writes; the load handshake still completes
    step(1, 0, 32'h77, 1, 0, 32'hDEAD, 0, a);
    chk("t4_acc", DW'(a), 1);
    chk("t4_wen", DW'(rf_wen), 0);
    chk("t4_q", DW'(q_count), 0);

    // T5 WAW kill: queued x7=1 is overwritten by ALU x7=2 and dropped
    step(1, 3, 32'h3, 1, 7, 32'h1, 0, a);
    step(1, 7, 32'h2, 0, 0, 0, 0, a);
    chk("t5_alu", rf_wdata, 32'h2);
    chk("t5_q", DW'(q_count), 1);
    idle(1);
    chk("t5_kill_wen", DW'(rf_wen), 0);
    chk("t5_kill_q", DW'(q_count), 0);
    chk("t5_final", rf_wdata, 32'h2);
    idle(1);

    // Load accepted with ALU write to same rd is younger and survives
    step(1, 8, 32'h5, 1, 8, 32'h6, 0, a);
    idle(1);
    chk("young_wen", DW'(rf_wen), 1);
    chk("young_d", rf_wdata, 32'h6);

    // T1 reset mid-traffic with three queued entries
    for (int c = 0; c < 3; c++) step(1, 4, 32'h40, 1, AW'(11 + c), 32'h200 + c, 0, a);
    chk("t1_q3", DW'(q_count), 3);
    step(1, 4, 32'h41, 1, 15, 32'h300, 1, a);
    chk("t1_wen", DW'(rf_wen), 0);
    chk("t1_rdy", DW'(ld_ready), 0);
    step(1, 4, 32'h42, 1, 15, 32'h300, 1, a);
    chk("t1_q", DW'(q_count), 0);
    idle(1);
    chk("t1_rel", DW'(ld_ready), 1);
    chk("t1_rel_wen", DW'(rf_wen), 0);

`ifdef RF_WB_BYPASS_EN
    // T6 forwarding: youngest queued x9=0x33 beats registered x9=0x22
    byp_rs1 = 9;
    byp_rs2 = 0;
    step(1, 9, 32'h22, 1, 9, 32'h33, 0, a);
    chk("t6_hit", DW'(byp_hit1), 1);
    chk("t6_data", byp_data1, 32'h33);
    byp_rs1 = 0;
    #1;
    chk("t6_x0", DW'(byp_hit1), 0);
    byp_rs1 = 9;
    idle(2);
    byp_rs1 = 0;
`endif

    // Back-to-back bypass loads on an idle ALU
    for (int c = 0; c < 3; c++) step(0, 0, 0, 1, AW'(20 + c), 32'h400 + c, 0, a);
    chk("bp_rd", DW'(rf_rd), 22);
    chk("bp_q", DW'(q_count), 0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
